// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: SR/Cause/EPC/PRId, arbitration, eret.
// Optional CP0_BD_EN: branch-delay-slot aware EPC and Cause.BD.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h2020_1221
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic [4:0]  ExcCode_M,
    input  logic        BD_M,
    input  logic [5:0]  HWInt,
    input  logic        CP0We,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0WD,
    input  logic        EretM,
    output logic [31:0] CP0RD,
    output logic        Req,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut,
    output logic        EXL
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] sr, cause;
    logic        int_req, exc_req;
    logic        bd_take;
    logic [31:0] epc_take;

    assign sr    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCode_M != 5'd0) & ~exl_q;
    assign Req     = int_req | exc_req;

`ifdef CP0_BD_EN
    assign bd_take  = BD_M;
    assign epc_take = BD_M ? (PC_M - 32'd4) : PC_M;
`else
    // BD_M kept in the expression only so the port is not dangling.
    assign bd_take  = BD_M & 1'b0;
    assign epc_take = PC_M;
`endif

    assign HandlerPC = HANDLER_ADDR;
    assign EPCOut    = epc_q;
    assign EXL       = exl_q;

    always_comb begin
        CP0RD = 32'b0;
        case (CP0Addr)
            5'd12:   CP0RD = sr;
            5'd13:   CP0RD = cause;
            5'd14:   CP0RD = epc_q;
            5'd15:   CP0RD = PRID_VALUE;
            default: CP0RD = 32'b0;
        endcase
    end

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (Req) begin
            // The faulting instruction is squashed, so its mtc0/eret never land.
            exl_d     = 1'b1;
            epc_d     = epc_take;
            bd_d      = bd_take;
            exccode_d = int_req ? 5'd0 : ExcCode_M;
        end else begin
            if (CP0We) begin
                case (CP0Addr)
                    5'd12: begin
                        im_d  = CP0WD[15:10];
                        exl_d = CP0WD[1];
                        ie_d  = CP0WD[0];
                    end
                    5'd14:   epc_d = {CP0WD[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (EretM) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 6'b0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'b0;
            exccode_q <= 5'b0;
            epc_q     <= 32'b0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: word-level CP0 model plus directed literal checks.
// Honours CP0_BD_EN the same way the design does.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] HADDR = 32'h0000_4180;
    localparam logic [31:0] PRID  = 32'h2020_1221;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_M;
    logic [4:0]  ExcCode_M;
    logic        BD_M;
    logic [5:0]  HWInt;
    logic        CP0We;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0WD;
    logic        EretM;
    logic [31:0] CP0RD;
    logic        Req;
    logic [31:0] HandlerPC;
    logic [31:0] EPCOut;
    logic        EXL;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Architectural model: whole 32-bit register images.
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_exc_ctrl #(.HANDLER_ADDR(HADDR), .PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .PC_M(PC_M), .ExcCode_M(ExcCode_M),
        .BD_M(BD_M), .HWInt(HWInt), .CP0We(CP0We), .CP0Addr(CP0Addr),
        .CP0WD(CP0WD), .EretM(EretM), .CP0RD(CP0RD), .Req(Req),
        .HandlerPC(HandlerPC), .EPCOut(EPCOut), .EXL(EXL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_int();
        return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCode_M != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_rd();
        if (CP0Addr == 5'd12) return m_sr;
        if (CP0Addr == 5'd13) return m_cause;
        if (CP0Addr == 5'd14) return m_epc;
        if (CP0Addr == 5'd15) return PRID;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_sr = 0;
            m_cause = 0;
            m_epc = 0;
        end else if (m_req()) begin
            m_cause[15:10] = HWInt;
            m_cause[6:2] = m_int() ? 5'd0 : ExcCode_M;
            m_sr[1] = 1'b1;
`ifdef CP0_BD_EN
            m_epc = BD_M ? PC_M - 4 : PC_M;
            m_cause[31] = BD_M;
`else
            m_epc = PC_M;
            m_cause[31] = 1'b0;
`endif
        end else begin
            m_cause[15:10] = HWInt;
            if (CP0We && CP0Addr == 5'd12) m_sr = CP0WD & 32'h0000_FC03;
            if (CP0We && CP0Addr == 5'd14) m_epc = CP0WD & 32'hFFFF_FFFC;
            if (EretM) m_sr[1] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_Req", {31'b0, Req}, {31'b0, m_req()});
            chk("m_CP0RD", CP0RD, m_rd());
            chk("m_EPCOut", EPCOut, m_epc);
            chk("m_EXL", {31'b0, EXL}, {31'b0, m_sr[1]});
            chk("m_HandlerPC", HandlerPC, HADDR);
        end
    end

    task automatic idle();
        reset = 0; PC_M = 32'h0000_3000; ExcCode_M = 0; BD_M = 0;
        HWInt = 0; CP0We = 0; CP0Addr = 0; CP0WD = 0; EretM = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [5:0] hw,
                      input string name, input logic [31:0] exp);
        idle();
        HWInt = hw;
        CP0Addr = a;
        @(negedge clk);
        chk(name, CP0RD, exp);
        cyc();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        CP0We = 1; CP0Addr = a; CP0WD = d;
        cyc();
    endtask

    initial begin
        idle();
        reset = 1;
        cyc();
        started = 1'b1;
        cyc();

        rd(12, 0, "rst_sr", 32'h0);
        rd(13, 0, "rst_cause", 32'h0);
        rd(14, 0, "rst_epc", 32'h0);
        rd(15, 0, "prid", PRID);
        chk("rst_req", {31'b0, Req}, 32'h0);

        // interrupt entry
        wr(12, 32'h0000_FC01);
        idle();
        HWInt = 6'b000100; PC_M = 32'h3008; CP0Addr = 12;
        @(negedge clk);
        chk("int_req", {31'b0, Req}, 32'h1);
        chk("sr_wr", CP0RD, 32'h0000_FC01);
        cyc();
        chk("int_exl", {31'b0, EXL}, 32'h1);
        rd(13, 6'b000100, "int_cause", 32'h0000_1000);
        rd(14, 6'b000100, "int_epc", 32'h0000_3008);

        // masked while EXL=1, then eret and re-entry
        idle();
        HWInt = 6'b000100; ExcCode_M = 12; PC_M = 32'h3030; CP0Addr = 14;
        @(negedge clk);
        chk("nest_req", {31'b0, Req}, 32'h0);
        chk("nest_epc", CP0RD, 32'h0000_3008);
        cyc();
        idle();
        HWInt = 6'b000100; EretM = 1;
        cyc();
        chk("eret_exl", {31'b0, EXL}, 32'h0);
        idle();
        HWInt = 6'b000100; PC_M = 32'h3040;
        @(negedge clk);
        chk("reint_req", {31'b0, Req}, 32'h1);
        cyc();
        wr(12, 32'h0);

        // synchronous exception, concurrent mtc0 EPC discarded
        idle();
        ExcCode_M = 10; PC_M = 32'h3010;
        CP0We = 1; CP0Addr = 14; CP0WD = 32'hDEAD_BEE0;
        @(negedge clk);
        chk("exc_req", {31'b0, Req}, 32'h1);
        cyc();
        rd(14, 0, "exc_epc", 32'h0000_3010);
        rd(13, 0, "exc_cause", 32'h0000_0028);
        wr(13, 32'hFFFF_FFFF);
        rd(13, 0, "cause_ro", 32'h0000_0028);
        wr(12, 32'h0);

        // delay-slot exception
        idle();
        ExcCode_M = 4; BD_M = 1; PC_M = 32'h3020;
        cyc();
`ifdef CP0_BD_EN
        rd(14, 0, "bd_epc", 32'h0000_301C);
        rd(13, 0, "bd_cause", 32'h8000_0010);
`else
        rd(14, 0, "bd_epc", 32'h0000_3020);
        rd(13, 0, "bd_cause", 32'h0000_0010);
`endif

        // interrupt beats exception
        wr(12, 32'h0000_FC01);
        idle();
        HWInt = 6'b000001; ExcCode_M = 12; PC_M = 32'h3050;
        @(negedge clk);
        chk("prio_req", {31'b0, Req}, 32'h1);
        cyc();
        rd(13, 6'b000001, "prio_cause", 32'h0000_0400);

        // reset in the handler
        idle();
        reset = 1; ExcCode_M = 3;
        cyc();
        chk("rst2_exl", {31'b0, EXL}, 32'h0);
        rd(12, 0, "rst2_sr", 32'h0);
        rd(13, 0, "rst2_cause", 32'h0);
        rd(14, 0, "rst2_epc", 32'h0);
        rd(5, 0, "unmapped", 32'h0);

        // read-during-write returns old value
        idle();
        CP0We = 1; CP0Addr = 14; CP0WD = 32'h0000_1237;
        @(negedge clk);
        chk("rdw_old", CP0RD, 32'h0);
        cyc();
        rd(14, 0, "rdw_new", 32'h0000_1234);

        idle();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
